// File: rtl/jstk_poll_sched_if.sv
// Bundle between the joystick poll scheduler, the two SPI engines and the game logic.
interface jstk_poll_sched_if #(
  parameter int unsigned DATA_W = 40
);
  logic              enable;
  logic [1:0]        busy;
  logic [DATA_W-1:0] rx_data1;
  logic [DATA_W-1:0] rx_data2;
  logic [1:0]        snd_rec;
  logic [DATA_W-1:0] pl1_data;
  logic [DATA_W-1:0] pl2_data;
  logic [1:0]        pl_valid;
  logic [1:0]        err;
  logic              frame_tick;
  logic              overrun;

  modport master (
    input  enable, busy, rx_data1, rx_data2,
    output snd_rec, pl1_data, pl2_data, pl_valid, err, frame_tick, overrun
  );

  modport slave (
    output enable, busy, rx_data1, rx_data2,
    input  snd_rec, pl1_data, pl2_data, pl_valid, err, frame_tick, overrun
  );
endinterface

// File: rtl/jstk_poll_sched.sv
// Polls two joystick SPI engines one at a time per round, alternating the first
// player each round, latching results with per-transfer timeout and overrun tracking.
module jstk_poll_sched #(
  parameter int unsigned POLL_PERIOD = 500000,
  parameter int unsigned TIMEOUT     = 100000,
  parameter int unsigned DATA_W      = 40
) (
  input  logic              clk,
  input  logic              clr_n,
  jstk_poll_sched_if.master bus
);
  localparam int unsigned   PW       = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PER_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_HI, WAIT_LO, LATCH, TICK} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     per_q, per_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              cur_q, cur_d, sec_q, sec_d, fp_q, fp_d;
  logic              pend_q, pend_d, ovr_q, ovr_d;
  logic [DATA_W-1:0] pl1_q, pl1_d, pl2_q, pl2_d;
  logic [1:0]        val_q, val_d, err_q, err_d;
  logic [1:0]        snd;
  logic              tick, wrap, ovr_set, tmo_hit, advance;

  // Period counter; pend_q remembers a wrap missed during an overrunning round.
  always_comb begin
    wrap = 1'b0;
    if (state_q == IDLE && !bus.enable) begin
      per_d = '0;
    end else begin
      wrap  = (per_q == PER_LAST);
      per_d = wrap ? '0 : per_q + PW'(1);
    end
    ovr_set = wrap && (state_q != IDLE) && (state_q != TICK);
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    cur_d   = cur_q;
    sec_d   = sec_q;
    fp_d    = fp_q;
    pend_d  = pend_q | ovr_set;
    ovr_d   = ovr_q | ovr_set;
    pl1_d   = pl1_q;
    pl2_d   = pl2_q;
    val_d   = val_q;
    err_d   = err_q;
    snd     = '0;
    tick    = 1'b0;
    advance = 1'b0;
    // tmo_q counts cycles since REQ entry; the last allowed cycle is TIMEOUT-1.
    tmo_hit = (tmo_q == TMO_LAST);

    unique case (state_q)
      IDLE: begin
        if (bus.enable && (per_q == '0 || pend_q)) begin
          cur_d   = fp_q;
          sec_d   = 1'b0;
          tmo_d   = '0;
          pend_d  = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_hit) begin
          err_d[cur_q] = 1'b1;
          val_d[cur_q] = 1'b0;
          advance      = 1'b1;
        end else if (!bus.busy[cur_q]) begin
          snd[cur_q] = 1'b1;
          state_d    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_hit) begin
          err_d[cur_q] = 1'b1;
          val_d[cur_q] = 1'b0;
          advance      = 1'b1;
        end else if (bus.busy[cur_q]) begin
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        tmo_d = tmo_q + TW'(1);
        if (!bus.busy[cur_q]) begin
          state_d = LATCH;
        end else if (tmo_hit) begin
          err_d[cur_q] = 1'b1;
          val_d[cur_q] = 1'b0;
          advance      = 1'b1;
        end
      end
      LATCH: begin
        if (cur_q == 1'b0) pl1_d = bus.rx_data1;
        else               pl2_d = bus.rx_data2;
        val_d[cur_q] = 1'b1;
        err_d[cur_q] = 1'b0;
        advance      = 1'b1;
      end
      TICK: begin
        tick    = 1'b1;
        fp_d    = ~fp_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (!sec_q) begin
        cur_d   = ~cur_q;
        sec_d   = 1'b1;
        tmo_d   = '0;
        state_d = REQ;
      end else begin
        state_d = TICK;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      per_q   <= '0;
      tmo_q   <= '0;
      cur_q   <= 1'b0;
      sec_q   <= 1'b0;
      fp_q    <= 1'b0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      pl1_q   <= '0;
      pl2_q   <= '0;
      val_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      tmo_q   <= tmo_d;
      cur_q   <= cur_d;
      sec_q   <= sec_d;
      fp_q    <= fp_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      pl1_q   <= pl1_d;
      pl2_q   <= pl2_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  end

  assign bus.snd_rec    = snd;
  assign bus.frame_tick = tick;
  assign bus.pl1_data   = pl1_q;
  assign bus.pl2_data   = pl2_q;
  assign bus.pl_valid   = val_q;
  assign bus.err        = err_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_jstk_poll_sched.sv
// Bench for jstk_poll_sched: randomized engine models drive two scheduler instances
// (normal period and a short period that forces overruns).
module tb_jstk_poll_sched;
  localparam int unsigned DW  = 40;
  localparam int unsigned TMO = 20;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  jstk_poll_sched_if #(.DATA_W(DW)) b ();
  jstk_poll_sched_if #(.DATA_W(DW)) ob ();

  jstk_poll_sched #(.POLL_PERIOD(100), .TIMEOUT(TMO), .DATA_W(DW)) dut (
    .clk(clk), .clr_n(clr_n), .bus(b));
  jstk_poll_sched #(.POLL_PERIOD(25), .TIMEOUT(TMO), .DATA_W(DW)) dut_ovr (
    .clk(clk), .clr_n(clr_n), .bus(ob));

  // engines 0,1 serve dut; engines 2,3 serve dut_ovr
  logic          en, oen;
  logic          busy_v [4];
  logic [DW-1:0] rx_v   [4];
  logic [DW-1:0] nxt_rx [4];
  int            dly [4];
  int            len [4];
  bit            never [4];
  int            ph  [4];
  int            cnt [4];

  assign b.enable    = en;
  assign b.busy      = {busy_v[1], busy_v[0]};
  assign b.rx_data1  = rx_v[0];
  assign b.rx_data2  = rx_v[1];
  assign ob.enable   = oen;
  assign ob.busy     = {busy_v[3], busy_v[2]};
  assign ob.rx_data1 = rx_v[2];
  assign ob.rx_data2 = rx_v[3];

  int unsigned cyc = 0;
  int unsigned both_cnt = 0;
  int unsigned cmp_n = 0;
  int unsigned err_n = 0;
  int unsigned round_start = 0;
  int          exp_fp = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (b.snd_rec == 2'b11 || ob.snd_rec == 2'b11) both_cnt <= both_cnt + 1;

  // Engine model: busy rises dly cycles after the snd_rec cycle and stays high len cycles.
  initial begin : engines
    logic [3:0]  s;
    logic [63:0] r64;
    for (int i = 0; i < 4; i++) begin
      busy_v[i] = 1'b0; rx_v[i] = '0; ph[i] = 0; cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      s = {ob.snd_rec, b.snd_rec};
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (ph[i] == 2) begin
          if (cnt[i] == 0) begin busy_v[i] = 1'b0; ph[i] = 0; end
          else cnt[i]--;
        end
        if (ph[i] == 0 && s[i] && !never[i]) begin ph[i] = 1; cnt[i] = dly[i] - 1; end
        if (ph[i] == 1) begin
          if (cnt[i] == 0) begin
            busy_v[i] = 1'b1;
            rx_v[i]   = nxt_rx[i];
            r64       = {$urandom(), $urandom()};
            nxt_rx[i] = r64[DW-1:0];
            ph[i]     = 2;
            cnt[i]    = len[i] - 1;
          end else cnt[i]--;
        end
      end
    end
  end

  function automatic logic [87:0] outs(input bit o);
    if (o) return {ob.snd_rec, ob.pl1_data, ob.pl2_data, ob.pl_valid, ob.err, ob.frame_tick, ob.overrun};
    return {b.snd_rec, b.pl1_data, b.pl2_data, b.pl_valid, b.err, b.frame_tick, b.overrun};
  endfunction

  task automatic wait_snd(input bit o, input int unsigned maxc, output int eng,
                          output int unsigned at, output int ticks);
    logic [1:0] s;
    eng = -1; at = 0; ticks = 0;
    for (int unsigned k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (o ? ob.frame_tick : b.frame_tick) ticks++;
      s = o ? ob.snd_rec : b.snd_rec;
      if (s != 2'b00) begin eng = s[1] ? 1 : 0; at = cyc; return; end
    end
  endtask

  task automatic wait_tick(input bit o, input int unsigned maxc, output bit ok, output int unsigned at);
    ok = 1'b0; at = 0;
    for (int unsigned k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (o ? ob.frame_tick : b.frame_tick) begin ok = 1'b1; at = cyc; return; end
    end
  endtask

  task automatic set_engine(input int i, input int d, input int l);
    dly[i] = d; len[i] = l; never[i] = 1'b0;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; en = 1'b0; oen = 1'b0;
    repeat (3) @(negedge clk);
    cmp_n++;
    if (outs(0) !== '0 || outs(1) !== '0) begin
      err_n++; $display("FAIL reset_outputs: got %h / %h required 0", outs(0), outs(1));
    end
    @(posedge clk); #1 clr_n = 1'b1;
  endtask

  task automatic test_basic();
    int e, tk; int unsigned t; bit ok;
    nxt_rx[0] = 40'hA5A5A5A5A5;
    @(posedge clk); #1 en = 1'b1;
    wait_snd(0, 50, e, t, tk);
    cmp_n++;
    if (e !== 0) begin err_n++; $display("FAIL basic_first_engine: got %0d required 0", e); end
    round_start = t;
    wait_snd(0, 50, e, t, tk);
    cmp_n++;
    if (e !== 1) begin err_n++; $display("FAIL basic_second_engine: got %0d required 1", e); end
    cmp_n++;
    if (b.pl1_data !== 40'hA5A5A5A5A5) begin
      err_n++; $display("FAIL basic_pl1_data: got %h required a5a5a5a5a5", b.pl1_data);
    end
    wait_tick(0, 50, ok, t);
    cmp_n++;
    if (ok !== 1'b1) begin err_n++; $display("FAIL basic_tick: got none required one"); end
    cmp_n++;
    if (b.pl2_data !== rx_v[1] || b.pl_valid !== 2'b11 || b.err !== 2'b00) begin
      err_n++; $display("FAIL basic_result: got %h v=%b e=%b required %h v=11 e=00",
                        b.pl2_data, b.pl_valid, b.err, rx_v[1]);
    end
    exp_fp = 1;
  endtask

  task automatic test_alternate();
    int e, tk; int unsigned t; bit ok;
    for (int r = 0; r < 4; r++) begin
      set_engine(0, $urandom_range(1, 4), $urandom_range(1, 8));
      set_engine(1, $urandom_range(1, 4), $urandom_range(1, 8));
      wait_snd(0, 150, e, t, tk);
      cmp_n++;
      if (e !== exp_fp || t - round_start !== 100 || tk !== 0) begin
        err_n++; $display("FAIL alt_round_start: got eng=%0d gap=%0d ticks=%0d required eng=%0d gap=100 ticks=0",
                          e, t - round_start, tk, exp_fp);
      end
      round_start = t;
      wait_snd(0, 50, e, t, tk);
      cmp_n++;
      if (e !== 1 - exp_fp) begin
        err_n++; $display("FAIL alt_second_engine: got %0d required %0d", e, 1 - exp_fp);
      end
      wait_tick(0, 50, ok, t);
      cmp_n++;
      if (!ok || b.pl1_data !== rx_v[0] || b.pl2_data !== rx_v[1] || b.pl_valid !== 2'b11
          || b.err !== 2'b00 || b.overrun !== 1'b0) begin
        err_n++; $display("FAIL alt_result: got tick=%0d %h %h v=%b e=%b ov=%b required tick=1 %h %h v=11 e=00 ov=0",
                          ok, b.pl1_data, b.pl2_data, b.pl_valid, b.err, b.overrun, rx_v[0], rx_v[1]);
      end
      exp_fp = 1 - exp_fp;
    end
  endtask

  task automatic test_timeout();
    int e, tk; int unsigned t; bit ok;
    logic [DW-1:0] old2;
    set_engine(0, 2, 5);
    set_engine(1, 2, 5);
    never[1] = 1'b1;
    old2 = rx_v[1];
    e = -1;
    for (int k = 0; k < 2 && e != 1; k++) wait_snd(0, 150, e, t, tk);
    cmp_n++;
    if (e !== 1) begin err_n++; $display("FAIL tmo_req: got %0d required 1", e); end
    repeat (TMO - 1) @(negedge clk);
    cmp_n++;
    if (b.err[1] !== 1'b0) begin err_n++; $display("FAIL tmo_early: got err1=%b required 0", b.err[1]); end
    @(negedge clk);
    cmp_n++;
    if (b.err[1] !== 1'b1 || b.pl_valid[1] !== 1'b0) begin
      err_n++; $display("FAIL tmo_flag: got err1=%b val1=%b required 1 0", b.err[1], b.pl_valid[1]);
    end
    never[1] = 1'b0;
    wait_tick(0, 50, ok, t);
    cmp_n++;
    if (!ok || b.pl2_data !== old2 || b.err[1] !== 1'b1) begin
      err_n++; $display("FAIL tmo_round: got tick=%0d pl2=%h err1=%b required tick=1 pl2=%h err1=1",
                        ok, b.pl2_data, b.err[1], old2);
    end
    wait_tick(0, 150, ok, t);
    cmp_n++;
    if (!ok || b.err !== 2'b00 || b.pl_valid !== 2'b11 || b.pl2_data !== rx_v[1]) begin
      err_n++; $display("FAIL tmo_recover: got tick=%0d err=%b v=%b pl2=%h required tick=1 err=00 v=11 pl2=%h",
                        ok, b.err, b.pl_valid, b.pl2_data, rx_v[1]);
    end
    exp_fp = 1 - exp_fp;
  endtask

  // Player 0 completes on the last allowed cycle (dly+len = TMO-1), then one cycle later.
  task automatic test_completion_edge();
    bit ok; int unsigned t;
    logic [DW-1:0] old1;
    for (int k = 0; k < 2; k++) begin
      set_engine(0, 2, TMO - 3 + k);
      old1 = b.pl1_data;
      wait_tick(0, 250, ok, t);
      cmp_n++;
      if (k == 0 && (!ok || b.pl_valid[0] !== 1'b1 || b.err[0] !== 1'b0 || b.pl1_data !== rx_v[0])) begin
        err_n++; $display("FAIL edge_complete_wins: got tick=%0d v0=%b e0=%b pl1=%h required 1 1 0 %h",
                          ok, b.pl_valid[0], b.err[0], b.pl1_data, rx_v[0]);
      end
      if (k == 1 && (!ok || b.pl_valid[0] !== 1'b0 || b.err[0] !== 1'b1 || b.pl1_data !== old1)) begin
        err_n++; $display("FAIL edge_timeout: got tick=%0d v0=%b e0=%b pl1=%h required 1 0 1 %h",
                          ok, b.pl_valid[0], b.err[0], b.pl1_data, old1);
      end
    end
    set_engine(0, 2, 5);
  endtask

  task automatic test_overrun();
    int e, tk; int unsigned t0, t; bit ok;
    set_engine(2, 2, 150);
    set_engine(3, 2, 5);
    @(posedge clk); #1 oen = 1'b1;
    wait_snd(1, 20, e, t0, tk);
    cmp_n++;
    if (e !== 0 || ob.overrun !== 1'b0) begin
      err_n++; $display("FAIL ovr_start: got eng=%0d ov=%b required 0 0", e, ob.overrun);
    end
    wait_tick(1, 200, ok, t);
    cmp_n++;
    if (!ok || ob.overrun !== 1'b1 || ob.err !== 2'b01 || ob.pl_valid !== 2'b10 || ob.pl2_data !== rx_v[3]) begin
      err_n++; $display("FAIL ovr_round: got tick=%0d ov=%b err=%b v=%b pl2=%h required 1 1 01 10 %h",
                        ok, ob.overrun, ob.err, ob.pl_valid, ob.pl2_data, rx_v[3]);
    end
    wait_snd(1, 10, e, t0, tk);
    cmp_n++;
    if (e !== 1 || t0 - t !== 2) begin
      err_n++; $display("FAIL ovr_restart: got eng=%0d gap=%0d required 1 2", e, t0 - t);
    end
    oen = 1'b0;
  endtask

  task automatic test_midreset();
    int e, tk; int unsigned t; bit ok;
    wait_snd(0, 150, e, t, tk);
    repeat (3) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    cmp_n++;
    if (outs(0) !== '0 || outs(1) !== '0) begin
      err_n++; $display("FAIL midreset_async: got %h / %h required 0", outs(0), outs(1));
    end
    @(negedge clk) clr_n = 1'b1;
    exp_fp = 0;
    wait_snd(0, 150, e, t, tk);
    cmp_n++;
    if (e !== 0) begin err_n++; $display("FAIL midreset_first: got %0d required 0", e); end
    wait_tick(0, 100, ok, t);
    exp_fp = 1;
  endtask

  task automatic test_enable_drop();
    int e, tk; int unsigned t;
    int ticks = 0, snd_before = 0, snd_after = 0, since = 0;
    wait_snd(0, 150, e, t, tk);
    cmp_n++;
    if (e !== exp_fp) begin err_n++; $display("FAIL drop_first: got %0d required %0d", e, exp_fp); end
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 500 && since < 300; k++) begin
      @(negedge clk);
      if (b.snd_rec != 2'b00) begin
        if (ticks == 0) snd_before++; else snd_after++;
      end
      if (ticks > 0) since++;
      if (b.frame_tick) ticks++;
    end
    cmp_n++;
    if (ticks !== 1 || snd_before !== 1 || snd_after !== 0) begin
      err_n++; $display("FAIL drop_idle: got ticks=%0d before=%0d after=%0d required 1 1 0",
                        ticks, snd_before, snd_after);
    end
  endtask

  task automatic test_exclusive();
    cmp_n++;
    if (both_cnt !== 0) begin err_n++; $display("FAIL snd_exclusive: got %0d dual pulses required 0", both_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      dly[i] = 2; len[i] = 5; never[i] = 1'b0; nxt_rx[i] = DW'($urandom());
    end
    test_reset();
    test_basic();
    test_alternate();
    test_timeout();
    test_completion_edge();
    test_overrun();
    test_midreset();
    test_enable_drop();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
